// File: rtl/alu_reservation_station.sv
// ALU reservation station: age-ordered issue buffer that captures pending operands
// from the result broadcast buses and issues the oldest fully-ready entry each cycle.

package alu_rs_pkg;
    localparam int XLEN   = 32;
    localparam int PHYS_W = 6;

    typedef union packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] tag;
    } OperandContent;

    typedef struct packed {
        logic          valid;
        OperandContent content;
    } Operand;

    typedef struct packed {
        logic [2:0]        funct3;
        logic [1:0]        aux_op;
        logic [3:0]        commit_id;
        logic [PHYS_W-1:0] dest_phys;
        logic [4:0]        dest_logic;
        Operand            src1;
        Operand            src2;
    } AluInstr;

    typedef struct packed {
        logic [PHYS_W-1:0] dest_phys;
        logic [XLEN-1:0]   data;
    } WbPayload;

    typedef union packed {
        WbPayload                 wb;
        logic [PHYS_W+XLEN-1:0]   raw;
    } ResultContent;

    typedef struct packed {
        logic [1:0]   kind;
        ResultContent content;
    } Result;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int N_RESULT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                dispatch_valid,
    input  AluInstr             dispatch_instr,
    output logic                dispatch_ready,
    input  logic [N_RESULT-1:0] result_valid,
    input  Result               results [N_RESULT],
    output logic                issue_valid,
    output AluInstr             issue_instr,
    input  logic                issue_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    AluInstr          ent_q [DEPTH];
    AluInstr          ent_d [DEPTH];
    logic [DEPTH-1:0] occ_q;
    logic [DEPTH-1:0] occ_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] dispatch_pos;
    logic [IDX_W-1:0] sel;
    logic             fire_issue;
    logic             fire_dispatch;

    // Lowest-index matching kind-0 broadcast wins; already-valid operands are left alone.
    function automatic Operand wake(input Operand op);
        Operand r;
        r = op;
        for (int b = 0; b < N_RESULT; b++) begin
            if (!r.valid && result_valid[b] && results[b].kind == 2'd0 &&
                op.content.tag == XLEN'(results[b].content.wb.dest_phys)) begin
                r.valid        = 1'b1;
                r.content.data = results[b].content.wb.data;
            end
        end
        return r;
    endfunction

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(occ_q[i]);
        end
    end

    assign dispatch_ready = count < CNT_W'(DEPTH);

    always_comb begin
        issue_valid = 1'b0;
        sel         = '0;
        issue_instr = ent_q[0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (occ_q[i] && ent_q[i].src1.valid && ent_q[i].src2.valid) begin
                issue_valid = 1'b1;
                sel         = IDX_W'(i);
                issue_instr = ent_q[i];
            end
        end
    end

    // Compact over the issued slot first, then wake the shifted entries, then append.
    always_comb begin
        fire_issue    = issue_valid && issue_ready;
        fire_dispatch = dispatch_valid && dispatch_ready;
        dispatch_pos  = count - CNT_W'(fire_issue);
        occ_d         = occ_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (fire_issue && i >= int'(sel)) begin
                ent_d[i] = ent_q[i+1];
                occ_d[i] = occ_q[i+1];
            end
        end
        if (fire_issue) begin
            occ_d[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_d[i]) begin
                ent_d[i].src1 = wake(ent_d[i].src1);
                ent_d[i].src2 = wake(ent_d[i].src2);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (fire_dispatch && dispatch_pos == CNT_W'(i)) begin
                ent_d[i]      = dispatch_instr;
                ent_d[i].src1 = wake(dispatch_instr.src1);
                ent_d[i].src2 = wake(dispatch_instr.src2);
                occ_d[i]      = 1'b1;
            end
        end
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus randomized
// traffic compared against a queue-based model of the issue buffer.

module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    localparam int DEPTH = 4;
    localparam int NR    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          dispatch_valid = 1'b0;
    AluInstr       dispatch_instr = '0;
    logic          dispatch_ready;
    logic [NR-1:0] result_valid = '0;
    Result         results [NR];
    logic          issue_valid;
    AluInstr       issue_instr;
    logic          issue_ready = 1'b0;

    AluInstr mq[$];
    int      total = 0;
    int      bad = 0;

    always #5 clk = ~clk;

    alu_reservation_station #(.DEPTH(DEPTH), .N_RESULT(NR)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_instr(dispatch_instr),
        .dispatch_ready(dispatch_ready), .result_valid(result_valid),
        .results(results), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_ready(issue_ready)
    );

    function automatic AluInstr mk(input logic [3:0] cid, input bit v1, input logic [31:0] x1,
                                   input bit v2, input logic [31:0] x2, input logic [2:0] f3);
        AluInstr e;
        e.funct3       = f3;
        e.aux_op       = 2'($urandom);
        e.commit_id    = cid;
        e.dest_phys    = 6'($urandom);
        e.dest_logic   = 5'($urandom);
        e.src1.valid   = v1;
        e.src1.content = x1;
        e.src2.valid   = v2;
        e.src2.content = x2;
        return e;
    endfunction

    task automatic set_bus(input int b, input logic [1:0] kind, input logic [5:0] dest,
                           input logic [31:0] data);
        Result r;
        r.kind                   = kind;
        r.content.wb.dest_phys   = dest;
        r.content.wb.data        = data;
        results[b]               = r;
        result_valid[b]          = 1'b1;
    endtask

    function automatic Operand m_wake(input Operand op);
        Operand r;
        r = op;
        if (op.valid) return r;
        for (int b = 0; b < NR; b++) begin
            if (result_valid[b] && results[b].kind == 2'd0 &&
                op.content.tag == {26'd0, results[b].content.wb.dest_phys}) begin
                r.valid = 1'b1;
                r.content.data = results[b].content.wb.data;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int m_sel();
        foreach (mq[k]) if (mq[k].src1.valid && mq[k].src2.valid) return k;
        return -1;
    endfunction

    // Advance one clock: the model sees the same inputs the DUT samples at the edge.
    task automatic tick();
        int      s;
        bit      fi;
        bit      fd;
        AluInstr e;
        s  = m_sel();
        fi = (s >= 0) && issue_ready;
        fd = dispatch_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (fi) mq.delete(s);
            for (int k = 0; k < mq.size(); k++) begin
                e = mq[k];
                e.src1 = m_wake(e.src1);
                e.src2 = m_wake(e.src2);
                mq[k] = e;
            end
            if (fd) begin
                e = dispatch_instr;
                e.src1 = m_wake(e.src1);
                e.src2 = m_wake(e.src2);
                mq.push_back(e);
            end
        end
        @(negedge clk);
        dispatch_valid = 1'b0;
        result_valid   = '0;
        flush          = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            reset = 1'b1;
            tick();
        end
        total++;
        if (dispatch_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_dready got=%b want=1", dispatch_ready);
        end
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_ivalid got=%b want=0", issue_valid);
        end
        total++;
        if (issue_instr !== AluInstr'('0)) begin
            bad++; $display("[TB] FAIL reset_iinstr got=%h want=0", issue_instr);
        end
    endtask

    task automatic test_dispatch_issue();
        AluInstr a;
        a = mk(4'd1, 1'b1, 32'd5, 1'b1, 32'd3, 3'd1);
        dispatch_valid = 1'b1;
        dispatch_instr = a;
        issue_ready    = 1'b1;
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL empty_no_issue got=%b want=0", issue_valid);
        end
        tick();
        total++;
        if (issue_valid !== 1'b1 || issue_instr !== a) begin
            bad++; $display("[TB] FAIL basic_issue got=%b/%h want=1/%h", issue_valid, issue_instr, a);
        end
        tick();
        issue_ready = 1'b0;
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_drained got=%b want=0", issue_valid);
        end
    endtask

    task automatic test_wakeup();
        AluInstr b;
        b = mk(4'd2, 1'b0, 32'd12, 1'b1, 32'd9, 3'd2);
        dispatch_valid = 1'b1;
        dispatch_instr = b;
        tick();
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL pending_no_issue got=%b want=0", issue_valid);
        end
        set_bus(0, 2'd1, 6'd12, 32'hDEAD);
        tick();
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL kind_nonzero_wake got=%b want=0", issue_valid);
        end
        set_bus(0, 2'd0, 6'd12, 32'hDEAD);
        tick();
        total++;
        if (issue_valid !== 1'b1 || issue_instr.src1.valid !== 1'b1 ||
            issue_instr.src1.content.data !== 32'hDEAD) begin
            bad++; $display("[TB] FAIL wakeup_data got=%b/%h want=1/dead", issue_valid,
                            issue_instr.src1.content.data);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic test_same_cycle_capture();
        dispatch_valid = 1'b1;
        dispatch_instr = mk(4'd3, 1'b0, 32'd7, 1'b1, 32'd1, 3'd3);
        set_bus(0, 2'd0, 6'd8, 32'h1111);
        set_bus(1, 2'd0, 6'd7, 32'h1234);
        tick();
        total++;
        if (issue_valid !== 1'b1 || issue_instr.src1.content.data !== 32'h1234) begin
            bad++; $display("[TB] FAIL same_cycle_capture got=%b/%h want=1/1234", issue_valid,
                            issue_instr.src1.content.data);
        end
        issue_ready = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_instr = mk(4'd4, 1'b1, 32'd2, 1'b0, 32'd9, 3'd4);
        set_bus(0, 2'd0, 6'd9, 32'hAAAA);
        set_bus(1, 2'd0, 6'd9, 32'hBBBB);
        tick();
        total++;
        if (issue_instr.src2.content.data !== 32'hAAAA) begin
            bad++; $display("[TB] FAIL lowest_bus_wins got=%h want=aaaa", issue_instr.src2.content.data);
        end
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic test_age_order();
        for (int k = 0; k < DEPTH; k++) begin
            dispatch_valid = 1'b1;
            dispatch_instr = mk(4'(8 + k), 1'b0, 32'(20 + k), 1'b1, 32'd0, 3'd5);
            tick();
        end
        total++;
        if (dispatch_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL full_dready got=%b want=0", dispatch_ready);
        end
        set_bus(0, 2'd0, 6'd23, 32'h3333);
        set_bus(1, 2'd0, 6'd21, 32'h1111);
        tick();
        total++;
        if (issue_valid !== 1'b1 || issue_instr.commit_id !== 4'd9) begin
            bad++; $display("[TB] FAIL age_first got=%b/%0d want=1/9", issue_valid, issue_instr.commit_id);
        end
        issue_ready = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_instr = mk(4'd15, 1'b1, 32'd1, 1'b1, 32'd1, 3'd6);
        tick();
        issue_ready = 1'b0;
        total++;
        if (dispatch_ready !== 1'b1 || issue_instr.commit_id !== 4'd11 ||
            issue_instr.src1.content.data !== 32'h3333) begin
            bad++; $display("[TB] FAIL age_second got=%b/%0d want=1/11", dispatch_ready,
                            issue_instr.commit_id);
        end
        total++;
        if (mq.size() != 3 || m_sel() != 2) begin
            bad++; $display("[TB] FAIL full_refuse got=%0d want=3", mq.size());
        end
    endtask

    task automatic test_flush();
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_instr = mk(4'd5, 1'b1, 32'd4, 1'b0, 32'd30, 3'd0);
        tick();
        flush = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_instr = mk(4'd6, 1'b1, 32'd4, 1'b1, 32'd4, 3'd0);
        set_bus(0, 2'd0, 6'd30, 32'h5);
        tick();
        total++;
        if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_state got=%b/%b want=0/1", issue_valid, dispatch_ready);
        end
        tick();
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_dropped got=%b want=0", issue_valid);
        end
    endtask

    task automatic test_backpressure();
        AluInstr e;
        e = mk(4'd7, 1'b1, 32'h77, 1'b1, 32'h88, 3'd7);
        dispatch_valid = 1'b1;
        dispatch_instr = e;
        tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (issue_valid !== 1'b1 || issue_instr !== e) begin
                bad++; $display("[TB] FAIL hold_%0d got=%b/%h want=1/%h", k, issue_valid, issue_instr, e);
            end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL single_issue got=%b want=0", issue_valid);
        end
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 400; n++) begin
            s = m_sel();
            total++;
            if (dispatch_ready !== (mq.size() < DEPTH)) begin
                bad++; $display("[TB] FAIL rnd_dready cyc=%0d got=%b want=%b", n, dispatch_ready,
                                mq.size() < DEPTH);
            end
            total++;
            if (issue_valid !== (s >= 0)) begin
                bad++; $display("[TB] FAIL rnd_ivalid cyc=%0d got=%b want=%b", n, issue_valid, s >= 0);
            end
            if (s >= 0) begin
                total++;
                if (issue_instr !== mq[s]) begin
                    bad++; $display("[TB] FAIL rnd_iinstr cyc=%0d got=%h want=%h", n, issue_instr, mq[s]);
                end
            end
            reset          = ($urandom_range(99) == 0);
            flush          = ($urandom_range(39) == 0);
            issue_ready    = ($urandom_range(2) != 0);
            dispatch_valid = ($urandom_range(1) != 0);
            dispatch_instr = mk(4'($urandom), $urandom_range(1) == 1, 32'($urandom_range(7)),
                                $urandom_range(2) != 0, 32'($urandom_range(7)), 3'($urandom));
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(1) == 1)
                    set_bus(b, ($urandom_range(4) == 0) ? 2'd2 : 2'd0, 6'($urandom_range(7)),
                            $urandom);
            end
            tick();
        end
    endtask

    initial begin
        for (int b = 0; b < NR; b++) results[b] = '0;
        @(negedge clk);
        test_reset();
        test_dispatch_issue();
        test_wakeup();
        test_same_cycle_capture();
        test_age_order();
        test_flush();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
